// File: rtl/cadr_amem_pkg.sv
// Shared constants and types for the A-memory port controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ADDR_WIDTH / DATA_WIDTH / MEM_DEPTH : default A-memory geometry
//   state_e                             : controller state (CLEAR, RUN)
package cadr_amem_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 1024;

  // CLEAR: zero-filling the RAM after reset; RUN: normal arbitration.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/amem_wbuf.sv
// One-entry write buffer for A-memory write-backs, with read-address hit compare.
// Latency: load visible on valid_o/adr_o/data_o the cycle after load_i.
// Backpressure: none; the controller drains the entry before reloading it.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the entry)
//   load_i         : capture {adr_i, data_i}; entry becomes valid
//   drain_i        : entry written to RAM this cycle; empties unless load_i
//   adr_i, data_i  : write-back address and data
//   cmp_adr_i      : read address compared against the buffered address
//   valid_o, adr_o, data_o : current entry
//   hit_o          : entry address equals cmp_adr_i (qualify with valid_o)
module amem_wbuf #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] cmp_adr_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  hit_o
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] adr_q,   adr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;

  // A simultaneous load and drain means the old entry went to RAM this
  // cycle and the new one replaces it, so load wins.
  always_comb begin
    valid_d = valid_q;
    adr_d   = adr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      adr_d   = adr_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      adr_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign adr_o   = adr_q;
  assign data_o  = data_q;
  assign hit_o   = (adr_q == cmp_adr_i);

endmodule

// File: rtl/amem_port_ctl.sv
// A-memory front end: sole driver of the single-port RAM, arbitrating microcode
// reads against buffered write-backs, zero-filling after reset, forwarding to a_bus.
// Latency: read result on a_bus with a_valid one cycle after acceptance.
// Backpressure: rd_stall holds the reader while CLEAR runs or a full buffer must drain.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   rd_en, rd_adr, rd_stall    : A-source read request / hold-off
//   wr_en, wr_adr, wr_data     : destination write-back (never refused in RUN)
//   busy                       : zero-fill in progress
//   aadr, arp, awp, l          : combinational RAM address / read / write / data
//   amem                       : RAM registered read data (cycle after arp)
//   a_bus, a_valid             : read result (held) and its 1-cycle valid pulse
module amem_port_ctl #(
  parameter int ADDR_WIDTH     = cadr_amem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = cadr_amem_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH      = cadr_amem_pkg::MEM_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_adr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_adr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_stall,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] aadr,
  output logic                  arp,
  output logic                  awp,
  output logic [DATA_WIDTH-1:0] l,
  input  logic [DATA_WIDTH-1:0] amem,
  output logic [DATA_WIDTH-1:0] a_bus,
  output logic                  a_valid
);

  import cadr_amem_pkg::*;

  // One extra bit so the counter can never wrap while sweeping MEM_DEPTH.
  localparam int                CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CLR_LAST = CNT_WIDTH'(MEM_DEPTH - 1);
  localparam state_e            ST_INIT   = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  // Forwarding capture and result registers.
  logic                   a_valid_q;
  logic                   fwd_q;
  logic [DATA_WIDTH-1:0]  fwd_data_q;
  logic [DATA_WIDTH-1:0]  a_hold_q;
  logic [DATA_WIDTH-1:0]  a_res;

  // Write buffer interface.
  logic                   wb_load;
  logic                   wb_drain;
  logic                   wb_valid;
  logic [ADDR_WIDTH-1:0]  wb_adr;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   wb_hit;

  logic                   rd_acc;

  amem_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (wb_load),
    .drain_i   (wb_drain),
    .adr_i     (wr_adr),
    .data_i    (wr_data),
    .cmp_adr_i (rd_adr),
    .valid_o   (wb_valid),
    .adr_o     (wb_adr),
    .data_o    (wb_data),
    .hit_o     (wb_hit)
  );

  // Next state, RAM arbitration and buffer control. Everything that touches
  // the RAM is forced quiet while reset is asserted.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    arp       = 1'b0;
    awp       = 1'b0;
    aadr      = '0;
    l         = '0;
    rd_stall  = 1'b0;
    busy      = 1'b0;
    wb_load   = 1'b0;
    wb_drain  = 1'b0;
    rd_acc    = 1'b0;

    if (!reset) begin
      case (state_q)
        ST_CLEAR: begin
          // Write-backs arriving here are dropped: the RAM is being wiped.
          awp       = 1'b1;
          aadr      = clr_cnt_q[ADDR_WIDTH-1:0];
          busy      = 1'b1;
          rd_stall  = rd_en;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == CLR_LAST) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (rd_en && !(wb_valid && wr_en)) begin
            // Read wins unless a full buffer is about to be overwritten.
            arp     = 1'b1;
            aadr    = rd_adr;
            rd_acc  = 1'b1;
            wb_load = !wb_valid && wr_en;
          end else if (wb_valid) begin
            awp      = 1'b1;
            aadr     = wb_adr;
            l        = wb_data;
            rd_stall = rd_en;
            wb_load  = wr_en;
            wb_drain = !wr_en;
          end else begin
            wb_load = wr_en;
          end
        end

        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // A read of the buffered address must see the buffered data, because the
  // RAM does not hold it yet. The capture uses the buffer as it stands at
  // acceptance, so a same-cycle write to the read address is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      a_hold_q   <= '0;
    end else begin
      a_valid_q <= rd_acc;
      if (rd_acc) begin
        fwd_q      <= wb_valid && wb_hit;
        fwd_data_q <= wb_data;
      end
      if (a_valid_q) begin
        a_hold_q <= a_res;
      end
    end
  end

  // amem is only meaningful the cycle after arp, so the result is taken
  // live then and held from a register afterwards.
  assign a_res   = fwd_q ? fwd_data_q : amem;
  assign a_bus   = a_valid_q ? a_res : a_hold_q;
  assign a_valid = a_valid_q;

endmodule

// File: tb/tb_amem_port_ctl.sv
// Directed and random bench for amem_port_ctl with a behavioural registered RAM.
// Inputs driven 1 time unit after posedge; outputs checked before the next edge.
// Reads held while rd_stall is high; results checked against hand values and a reference array.
module tb_amem_port_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [9:0]  rd_adr;
  logic        wr_en;
  logic [9:0]  wr_adr;
  logic [31:0] wr_data;
  logic        rd_stall;
  logic        busy;
  logic [9:0]  aadr;
  logic        arp;
  logic        awp;
  logic [31:0] l;
  logic [31:0] amem;
  logic [31:0] a_bus;
  logic        a_valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:15];

  always #5 clk = ~clk;

  amem_port_ctl #(
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (32),
    .MEM_DEPTH      (1024),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_adr   (rd_adr),
    .wr_en    (wr_en),
    .wr_adr   (wr_adr),
    .wr_data  (wr_data),
    .rd_stall (rd_stall),
    .busy     (busy),
    .aadr     (aadr),
    .arp      (arp),
    .awp      (awp),
    .l        (l),
    .amem     (amem),
    .a_bus    (a_bus),
    .a_valid  (a_valid)
  );

  // Single-port RAM with registered read data that holds when not read.
  always @(posedge clk) begin
    if (awp) ram[aadr] <= l;
    if (arp) amem <= ram[aadr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic [9:0] ra, input logic we,
                       input logic [9:0] wa, input logic [31:0] wd);
    rd_en   = re;
    rd_adr  = ra;
    wr_en   = we;
    wr_adr  = wa;
    wr_data = wd;
    #1;
  endtask

  // Run n cycles of CLEAR starting at address 0, checking the sweep.
  task automatic run_clear(input int n);
    for (int i = 0; i < n; i++) begin
      drive(i[0], 10'd1, 1'b1, 10'd6, 32'h55);
      chk("clr_busy", busy, 1);
      chk("clr_awp", awp, 1);
      chk("clr_arp", arp, 0);
      chk("clr_aadr", aadr, i);
      chk("clr_l", l, 0);
      chk("clr_stall", rd_stall, i[0]);
      tick();
    end
  endtask

  task automatic read_expect(input string tag, input logic [9:0] ra, input logic [31:0] exp);
    drive(1'b1, ra, 1'b0, 10'd0, 32'd0);
    chk({tag, "_arp"}, arp, 1);
    chk({tag, "_aadr"}, aadr, ra);
    tick();
    chk({tag, "_vld"}, a_valid, 1);
    chk({tag, "_bus"}, a_bus, exp);
  endtask

  initial begin
    logic        re, we, hold, acc;
    logic [9:0]  ra, wa;
    logic [31:0] wd, exp;

    // Reset: RAM strobes and stall quiet even with requests present.
    reset = 1'b1;
    drive(1'b1, 10'd3, 1'b1, 10'd3, 32'h1234);
    chk("rst_arp", arp, 0);
    chk("rst_awp", awp, 0);
    chk("rst_stall", rd_stall, 0);
    tick();
    chk("rst_avalid", a_valid, 0);
    chk("rst_abus", a_bus, 0);
    reset = 1'b0;

    // Full zero-fill, writes presented during it are dropped.
    run_clear(1024);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    chk("clr_done_busy", busy, 0);
    chk("idle_aadr", aadr, 0);
    chk("idle_arp", arp, 0);
    chk("idle_awp", awp, 0);
    tick();

    read_expect("dropped6", 10'd6, 32'h0);

    // Write then read same address next cycle: forwarded from buffer.
    drive(1'b0, 10'd0, 1'b1, 10'd5, 32'hDEADBEEF);
    chk("w5_awp", awp, 0);
    tick();
    read_expect("fwd5", 10'd5, 32'hDEADBEEF);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    chk("drain5_awp", awp, 1);
    chk("drain5_aadr", aadr, 5);
    chk("drain5_l", l, 32'hDEADBEEF);
    tick();
    chk("hold5_vld", a_valid, 0);
    chk("hold5_bus", a_bus, 32'hDEADBEEF);

    // Full buffer + new write + read: drain wins, read stalls then proceeds.
    drive(1'b0, 10'd0, 1'b1, 10'd7, 32'h77);
    tick();
    drive(1'b1, 10'd3, 1'b1, 10'd9, 32'h99);
    chk("conf_awp", awp, 1);
    chk("conf_arp", arp, 0);
    chk("conf_aadr", aadr, 7);
    chk("conf_l", l, 32'h77);
    chk("conf_stall", rd_stall, 1);
    tick();
    chk("conf_vld", a_valid, 0);
    drive(1'b1, 10'd3, 1'b0, 10'd0, 32'd0);
    chk("conf_stall2", rd_stall, 0);
    read_expect("conf_rd3", 10'd3, 32'h0);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    chk("drain9_awp", awp, 1);
    chk("drain9_aadr", aadr, 9);
    chk("drain9_l", l, 32'h99);
    tick();
    read_expect("ram7", 10'd7, 32'h77);
    read_expect("ram9", 10'd9, 32'h99);

    // Same-cycle read and write of one address returns the old value.
    drive(1'b1, 10'd4, 1'b1, 10'd4, 32'h1);
    chk("same4_arp", arp, 1);
    chk("same4_aadr", aadr, 4);
    tick();
    chk("same4_vld", a_valid, 1);
    chk("same4_bus", a_bus, 32'h0);
    read_expect("next4", 10'd4, 32'h1);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    tick();
    read_expect("ram4", 10'd4, 32'h1);

    // Reset with a pending buffer entry: entry must vanish.
    drive(1'b0, 10'd0, 1'b1, 10'd20, 32'hABCD);
    tick();
    reset = 1'b1;
    drive(1'b1, 10'd20, 1'b0, 10'd0, 32'd0);
    chk("rst2_awp", awp, 0);
    chk("rst2_arp", arp, 0);
    tick();
    chk("rst2_vld", a_valid, 0);
    chk("rst2_bus", a_bus, 0);
    reset = 1'b0;

    // Interrupt CLEAR at clr_cnt=500; sweep must restart from 0.
    for (int i = 0; i < 500; i++) tick();
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    chk("mid_aadr500", aadr, 500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_vld", a_valid, 0);
    run_clear(1024);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    chk("mid_done_busy", busy, 0);
    chk("mid_idle_awp", awp, 0);
    tick();
    read_expect("lost20", 10'd20, 32'h0);
    read_expect("cleared5", 10'd5, 32'h0);

    // Random traffic over a small address window against a reference array.
    for (int a = 0; a < 16; a++) ref_mem[a] = 32'h0;
    hold = 1'b0;
    re = 1'b0;
    ra = 10'd0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        re = 1'($urandom_range(0, 1));
        ra = 10'($urandom_range(0, 15));
      end
      we = 1'($urandom_range(0, 1));
      wa = 10'($urandom_range(0, 15));
      wd = $urandom;
      drive(re, ra, we, wa, wd);
      if (!re) chk("rnd_nostall", rd_stall, 0);
      acc  = re && !rd_stall;
      hold = re && rd_stall;
      exp  = ref_mem[ra[3:0]];
      if (we) ref_mem[wa[3:0]] = wd;
      tick();
      if (acc) begin
        chk("rnd_vld", a_valid, 1);
        chk("rnd_bus", a_bus, exp);
      end else begin
        chk("rnd_novld", a_valid, 0);
      end
    end

    // Drain and read back every location: no write may be lost.
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'd0);
    tick();
    tick();
    for (int a = 0; a < 16; a++) begin
      read_expect("final", 10'(a), ref_mem[a]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
